// File: rtl/interleaver_sequencer.sv
// Interleaver sequencer: steps the interleaver through the N cycle indices of
// one junction, registers the returned address sets with their sweep number,
// and flags the final set of the junction with a one-cycle done pulse.
// Downstream back-pressure (stall) freezes progress without losing or
// repeating any set.
module interleaver_sequencer #(
    parameter  int fo = 2,                          // sweeps per junction
    parameter  int p  = 32,                         // left-hand neurons
    parameter  int z  = 8,                          // addresses per cycle
    localparam int N  = fo * p / z,                 // cycles per junction
    localparam int CW = (N > 1) ? $clog2(N) : 1,
    localparam int SW = (fo > 1) ? $clog2(fo) : 1,
    localparam int AW = $clog2(p) * z
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          stall,
    output logic [CW-1:0] cycle_index,
    input  logic [AW-1:0] mem_idx_in,
    output logic [AW-1:0] mem_idx_out,
    output logic          mem_idx_valid,
    output logic [SW-1:0] sweep,
    output logic          last_cycle,
    output logic          busy,
    output logic          done
);

    // Reject configurations where a junction does not split into a
    // power-of-two number of whole cycles.
    generate
        if ((N < 1) || ((p % z) != 0) || ((N & (N - 1)) != 0)) begin : g_bad_cfg
            $fatal(1, "interleaver_sequencer: p must be a multiple of z and fo*p/z a power of two");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state;
    logic [SW-1:0] sweep_next;
    logic          at_last;

    // The sweep number is the top bits of the cycle index; a single sweep is always 0.
    always_comb begin
        // NOTE: default first so every path assigns the signal and no latch is inferred.
        sweep_next = '0;
        if (fo > 1) begin
            sweep_next = cycle_index[CW-1 -: SW];
        end
    end

    assign at_last    = (cycle_index == CW'(N - 1));
    assign last_cycle = (state == RUN) && at_last;
    assign busy       = (state == RUN);

    // Junction FSM: accept start in IDLE, capture one address set per unstalled RUN cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cycle_index   <= '0;
            mem_idx_out   <= '0;
            sweep         <= '0;
            mem_idx_valid <= 1'b0;
            done          <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            mem_idx_valid <= 1'b0;
            done          <= 1'b0;
            case (state)
                IDLE: begin
                    cycle_index <= '0;
                    if (start) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!stall) begin
                        mem_idx_out   <= mem_idx_in;
                        sweep         <= sweep_next;
                        mem_idx_valid <= 1'b1;
                        if (at_last) begin
                            cycle_index <= '0;
                            done        <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            cycle_index <= cycle_index + CW'(1);
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    cycle_index <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interleaver_sequencer.sv
// Directed bench for interleaver_sequencer at fo=2, p=32, z=8 (N=8).
// A behavioural interleaver returns a distinct address set per cycle index;
// the bench tracks the index it expects each capture to carry.
module tb_interleaver_sequencer;

    localparam int N  = 8;
    localparam int CW = 3;
    localparam int SW = 1;
    localparam int AW = 40;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          stall;
    logic [CW-1:0] cycle_index;
    logic [AW-1:0] mem_idx_in;
    logic [AW-1:0] mem_idx_out;
    logic          mem_idx_valid;
    logic [SW-1:0] sweep;
    logic          last_cycle;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;
    int valid_sets = 0;

    interleaver_sequencer #(.fo(2), .p(32), .z(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .stall        (stall),
        .cycle_index  (cycle_index),
        .mem_idx_in   (mem_idx_in),
        .mem_idx_out  (mem_idx_out),
        .mem_idx_valid(mem_idx_valid),
        .sweep        (sweep),
        .last_cycle   (last_cycle),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Behavioural interleaver: lane k of index ci addresses neuron (4k + 5ci) mod 32.
    function automatic logic [AW-1:0] il(input int ci);
        logic [AW-1:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            r[k*5 +: 5] = 5'((k * 4 + ci * 5) % 32);
        end
        return r;
    endfunction

    assign mem_idx_in = il(int'(cycle_index));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are observed 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One unstalled RUN cycle that must capture the set for index idx.
    task automatic capture(input int idx);
        step();
        if (mem_idx_valid === 1'b1) valid_sets++;
        check($sformatf("valid[%0d]", idx), 64'(mem_idx_valid), 64'(1));
        check($sformatf("addr[%0d]", idx), 64'(mem_idx_out), 64'(il(idx)));
        check($sformatf("sweep[%0d]", idx), 64'(sweep), 64'(idx / 4));
        check($sformatf("done[%0d]", idx), 64'(done), 64'(idx == N - 1));
        check($sformatf("index_after[%0d]", idx), 64'(cycle_index), 64'((idx + 1) % N));
        check($sformatf("busy_after[%0d]", idx), 64'(busy), 64'(idx != N - 1));
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        stall = 1'b0;

        // Reset state
        step();
        check("rst_index", 64'(cycle_index), 64'(0));
        check("rst_addr", 64'(mem_idx_out), 64'(0));
        check("rst_sweep", 64'(sweep), 64'(0));
        check("rst_valid", 64'(mem_idx_valid), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        reset = 1'b0;

        // Plain junction: start honoured on the first edge after reset
        start = 1'b1;
        step();
        start = 1'b0;
        check("a_busy", 64'(busy), 64'(1));
        check("a_index0", 64'(cycle_index), 64'(0));
        check("a_valid0", 64'(mem_idx_valid), 64'(0));
        valid_sets = 0;
        for (int i = 0; i < N; i++) capture(i);
        check("a_sets", 64'(valid_sets), 64'(N));
        step();
        check("a_idle_valid", 64'(mem_idx_valid), 64'(0));
        check("a_idle_done", 64'(done), 64'(0));
        check("a_idle_busy", 64'(busy), 64'(0));
        check("a_idle_index", 64'(cycle_index), 64'(0));
        check("a_idle_hold", 64'(mem_idx_out), 64'(il(7)));
        check("a_idle_sweep", 64'(sweep), 64'(1));

        // Stall for 3 cycles while presenting index 5
        start = 1'b1;
        step();
        start = 1'b0;
        valid_sets = 0;
        for (int i = 0; i < 5; i++) capture(i);
        stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
            step();
            check("b_stall_index", 64'(cycle_index), 64'(5));
            check("b_stall_valid", 64'(mem_idx_valid), 64'(0));
            check("b_stall_addr", 64'(mem_idx_out), 64'(il(4)));
            check("b_stall_done", 64'(done), 64'(0));
        end
        stall = 1'b0;
        for (int i = 5; i < N; i++) capture(i);
        check("b_sets", 64'(valid_sets), 64'(N));
        step();
        check("b_idle_busy", 64'(busy), 64'(0));

        // Start held high: one non-valid cycle between done and the next index 0
        start = 1'b1;
        step();
        for (int i = 0; i < N; i++) capture(i);
        step();
        check("c_gap_valid", 64'(mem_idx_valid), 64'(0));
        check("c_gap_busy", 64'(busy), 64'(1));
        check("c_gap_index", 64'(cycle_index), 64'(0));
        capture(0);
        capture(1);
        start = 1'b0;
        for (int i = 2; i < N; i++) capture(i);
        step();
        check("c_end_busy", 64'(busy), 64'(0));

        // Stall on the last index delays done
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < N - 1; i++) capture(i);
        check("d_last_cycle", 64'(last_cycle), 64'(1));
        stall = 1'b1;
        for (int s = 0; s < 2; s++) begin
            step();
            check("d_stall_done", 64'(done), 64'(0));
            check("d_stall_valid", 64'(mem_idx_valid), 64'(0));
            check("d_stall_index", 64'(cycle_index), 64'(7));
            check("d_stall_busy", 64'(busy), 64'(1));
        end
        stall = 1'b0;
        capture(N - 1);
        check("d_last_clear", 64'(last_cycle), 64'(0));
        step();
        check("d_done_once", 64'(done), 64'(0));

        // Reset mid-junction at index 3
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) capture(i);
        check("e_index3", 64'(cycle_index), 64'(3));
        #2;
        reset = 1'b1;
        #1;
        check("e_async_index", 64'(cycle_index), 64'(0));
        check("e_async_addr", 64'(mem_idx_out), 64'(0));
        check("e_async_valid", 64'(mem_idx_valid), 64'(0));
        check("e_async_busy", 64'(busy), 64'(0));
        check("e_async_sweep", 64'(sweep), 64'(0));
        step();
        reset = 1'b0;
        for (int s = 0; s < 3; s++) begin
            step();
            check("e_abandon_done", 64'(done), 64'(0));
            check("e_abandon_valid", 64'(mem_idx_valid), 64'(0));
            check("e_abandon_busy", 64'(busy), 64'(0));
        end
        start = 1'b1;
        step();
        start = 1'b0;
        check("e_restart_index", 64'(cycle_index), 64'(0));
        check("e_restart_busy", 64'(busy), 64'(1));
        valid_sets = 0;
        for (int i = 0; i < N; i++) capture(i);
        check("e_sets", 64'(valid_sets), 64'(N));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/interleaver_sequencer.md
INTERLEAVER_SEQUENCER -- requirements
Module: interleaver_sequencer

Interface
REQ-001 SHALL have parameter fo, default 2, fan-out (number of sweeps per junction).
REQ-002 SHALL have parameter p, default 32, number of left-hand neurons.
REQ-003 SHALL have parameter z, default 8, degree of parallelism (addresses per cycle).
REQ-004 SHALL define derived constants: N = fo*p/z cycles per junction; CW = log2ceil(N); SW = log2ceil(fo), minimum 1; AW = log2ceil(p)*z.
REQ-005 SHALL have port clk, input, 1, rising-edge clock.
REQ-006 SHALL have port reset, input, 1; reset is asynchronous, active-high.
REQ-007 SHALL have port start, input, 1, request to process one junction.
REQ-008 SHALL have port stall, input, 1, downstream back-pressure that freezes progress.
REQ-009 SHALL have port cycle_index, output, CW, registered index driven to the interleaver.
REQ-010 SHALL have port mem_idx_in, input, AW, packed activation addresses returned combinationally by the interleaver for the current cycle_index.
REQ-011 SHALL have port mem_idx_out, output, AW, registered copy of mem_idx_in.
REQ-012 SHALL have port mem_idx_valid, output, 1, mem_idx_out holds a new address set this cycle.
REQ-013 SHALL have port sweep, output, SW, registered sweep number of the set on mem_idx_out.
REQ-014 SHALL have port last_cycle, output, 1, combinational, high when the RUN state is presenting cycle_index == N-1.
REQ-015 SHALL have port busy, output, 1, high in the RUN state.
REQ-016 SHALL have port done, output, 1, one-cycle pulse marking the final address set of the junction.

Function
REQ-017 SHALL implement a two-state FSM: IDLE and RUN.
REQ-018 In IDLE with start=1: next state is RUN, and cycle_index is 0. In IDLE with start=0: remain in IDLE.
REQ-019 In RUN with stall=0: on the next edge, mem_idx_out <= mem_idx_in, sweep <= cycle_index[CW-1:CW-SW] (0 when fo=1), mem_idx_valid <= 1, and cycle_index increments.
REQ-020 In RUN with stall=1: cycle_index, mem_idx_out and sweep hold their values, and mem_idx_valid <= 0.
REQ-021 In RUN with stall=0 and cycle_index == N-1: the capture per REQ-019 occurs, cycle_index wraps to 0, next state is IDLE, and done <= 1. The done pulse therefore coincides with mem_idx_valid of the last set.
REQ-022 done SHALL be low in every other cycle; mem_idx_valid SHALL be low in every cycle except the one following a capture.
REQ-023 start SHALL be ignored while in RUN.
REQ-024 start=1 in the cycle that done=1 (state is already IDLE) SHALL be accepted, giving back-to-back junctions with one idle cycle between the last capture and the next cycle 0.
REQ-025 In IDLE, cycle_index SHALL be 0, and mem_idx_out and sweep SHALL hold their last values.
REQ-026 Exactly N captures SHALL occur per accepted start, regardless of stall pattern. Their cycle_index values SHALL be 0..N-1 in order, with no skips or repeats.
REQ-027 An elaboration-time check SHALL be included: p mod z == 0, and N a power of two; otherwise simulation halts with a fatal error.

Reset
REQ-028 While reset=1, asynchronously: state = IDLE; cycle_index = 0; mem_idx_out = 0; sweep = 0; mem_idx_valid = 0; done = 0.
REQ-029 Reset asserted mid-junction SHALL abandon the junction: no done pulse, and no further valid sets until a new start.
REQ-030 After reset deasserts, the first start SHALL be honoured on the first rising edge.

Verification (fo=2, p=32, z=8, so N=8, CW=3, SW=1, AW=40)
REQ-031 Reset, then one start pulse with stall=0 -> cycle_index runs 0..7. mem_idx_valid is high for 8 consecutive cycles. sweep reads 0,0,0,0,1,1,1,1. done is high only in the 8th valid cycle. busy is low afterwards.
REQ-032 stall=1 for 3 cycles while cycle_index=5 -> cycle_index holds at 5. mem_idx_valid is low for 3 cycles. mem_idx_out is unchanged. There are still exactly 8 valid sets.
REQ-033 start held high continuously -> junctions repeat with exactly one non-valid cycle between the done cycle and the next set for index 0.
REQ-034 stall=1 at cycle_index=7 -> done is delayed until stall drops, then pulses once. cycle_index returns to 0.
REQ-035 reset asserted at cycle_index=3 -> all outputs are 0 immediately (asynchronous). No done pulse. A new start restarts at index 0.
REQ-036 Scoreboard with the interleaver connected -> each mem_idx_out equals the interleaver output for the cycle_index captured, using the default sweepstart pattern.
